// File: rtl/display_pkg.sv
// Shared types and colour constants for the display scan block.
// Colours are 3-bit RGB (MSB red); rgb_expand widens them to any colour width.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

  // Each channel gets w/3 bits; any leftover upper bits belong to red.
  function automatic int rgb_expand(logic [2:0] rgb, int w);
    int cw;
    int c;
    int r;
    r  = 0;
    cw = (w / 3 > 0) ? w / 3 : 1;
    for (int i = 0; i < w; i++) begin
      c = i / cw;
      if (c > 2) c = 2;
      if (rgb[c[1:0]]) r = r | (1 << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scan_spr_match.sv
// Priority sprite hit test for one pixel: the lowest-index enabled sprite
// sitting exactly on (px, py) wins; off-screen sprites never match.
module spr_match
  import display_pkg::*;
#(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int NUM_SPR = 4,
  parameter int COL_W   = 3
) (
  input  logic [7:0]               px,
  input  logic [6:0]               py,
  input  logic [NUM_SPR-1:0]       spr_en,
  input  logic [NUM_SPR*8-1:0]     spr_x,
  input  logic [NUM_SPR*7-1:0]     spr_y,
  input  logic [NUM_SPR*COL_W-1:0] spr_col,
  output logic                     hit,
  output logic [COL_W-1:0]         col
);

  always_comb begin
    hit = 1'b0;
    col = '0;
    // Walk downwards so the lowest matching index is the last to assign.
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (spr_en[i] &&
          (int'(spr_x[8*i +: 8]) < H_RES) && (int'(spr_y[7*i +: 7]) < V_RES) &&
          (spr_x[8*i +: 8] == px) && (spr_y[7*i +: 7] == py)) begin
        hit = 1'b1;
        col = spr_col[COL_W*i +: COL_W];
      end
    end
  end

endmodule

// File: rtl/display_scan.sv
// Raster frame generator: optional clear pass, then a draw pass of sprites over a bullet grid.
// Define DISPLAY_SCAN_LATCH_EN to freeze sprite inputs at start for a tear-free frame.
module display_scan
  import display_pkg::*;
#(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int NUM_SPR = 4,
  parameter int COL_W   = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     clear_req,
  input  logic [NUM_SPR-1:0]       spr_en,
  input  logic [NUM_SPR*8-1:0]     spr_x,
  input  logic [NUM_SPR*7-1:0]     spr_y,
  input  logic [NUM_SPR*COL_W-1:0] spr_col,
  input  logic [H_RES*V_RES-1:0]   grid,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [COL_W-1:0]         colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int PIX_W = $clog2(H_RES * V_RES);
  localparam logic [COL_W-1:0] BLACK_C = COL_W'(rgb_expand(BLACK, COL_W));
  localparam logic [COL_W-1:0] GREEN_C = COL_W'(rgb_expand(GREEN, COL_W));

  state_e           state_q, state_d;
  logic [7:0]       cnt_x_q, cnt_x_d;
  logic [6:0]       cnt_y_q, cnt_y_d;
  logic [7:0]       x_q;
  logic [6:0]       y_q;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             done_q, done_d;
  logic             scanning, last_pix, accept;
  logic [PIX_W-1:0] pix_idx;

  logic [NUM_SPR-1:0]       s_en;
  logic [NUM_SPR*8-1:0]     s_x;
  logic [NUM_SPR*7-1:0]     s_y;
  logic [NUM_SPR*COL_W-1:0] s_col;
  logic                     hit;
  logic [COL_W-1:0]         hit_col;

  assign scanning = (state_q == CLEAR) || (state_q == DRAW);
  assign last_pix = (cnt_x_q == 8'(H_RES - 1)) && (cnt_y_q == 7'(V_RES - 1));
  assign accept   = (state_q == IDLE) && start;
  assign pix_idx  = PIX_W'(cnt_y_q) * PIX_W'(H_RES) + PIX_W'(cnt_x_q);

`ifdef DISPLAY_SCAN_LATCH_EN
  logic [NUM_SPR-1:0]       spr_en_q;
  logic [NUM_SPR*8-1:0]     spr_x_q;
  logic [NUM_SPR*7-1:0]     spr_y_q;
  logic [NUM_SPR*COL_W-1:0] spr_col_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spr_en_q  <= '0;
      spr_x_q   <= '0;
      spr_y_q   <= '0;
      spr_col_q <= '0;
    end else if (accept) begin
      spr_en_q  <= spr_en;
      spr_x_q   <= spr_x;
      spr_y_q   <= spr_y;
      spr_col_q <= spr_col;
    end
  end

  assign s_en  = spr_en_q;
  assign s_x   = spr_x_q;
  assign s_y   = spr_y_q;
  assign s_col = spr_col_q;
`else
  assign s_en  = spr_en;
  assign s_x   = spr_x;
  assign s_y   = spr_y;
  assign s_col = spr_col;
`endif

  spr_match #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .NUM_SPR(NUM_SPR),
    .COL_W  (COL_W)
  ) u_spr_match (
    .px     (cnt_x_q),
    .py     (cnt_y_q),
    .spr_en (s_en),
    .spr_x  (s_x),
    .spr_y  (s_y),
    .spr_col(s_col),
    .hit    (hit),
    .col    (hit_col)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = clear_req ? CLEAR : DRAW;
      CLEAR:   if (last_pix) state_d = DRAW;
      DRAW:    if (last_pix) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters wrap back to (0,0) on the last pixel, so IDLE always sits at the origin.
  always_comb begin
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;
    colour_d = BLACK_C;
    plot_d   = scanning;
    done_d   = (state_q == FIN);
    if (scanning) begin
      if (cnt_x_q == 8'(H_RES - 1)) begin
        cnt_x_d = '0;
        cnt_y_d = last_pix ? '0 : cnt_y_q + 7'd1;
      end else begin
        cnt_x_d = cnt_x_q + 8'd1;
      end
    end
    if (state_q == DRAW) begin
      if (hit)                colour_d = hit_col;
      else if (grid[pix_idx]) colour_d = GREEN_C;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
      x_q      <= cnt_x_q;
      y_q      <= cnt_y_q;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with an expected-pixel queue per pass.
module tb_display_scan;

  localparam int H    = 160;
  localparam int V    = 120;
  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int NPIX = H * V;

  localparam logic [2:0] C_BLK = 3'b000;
  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_GRN = 3'b010;
  localparam logic [2:0] C_BLU = 3'b001;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic             clear_req;
  logic [N-1:0]     spr_en;
  logic [N*8-1:0]   spr_x;
  logic [N*7-1:0]   spr_y;
  logic [N*CW-1:0]  spr_col;
  logic [H*V-1:0]   grid;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [CW-1:0]    colour;
  logic             plot;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  pix_t       exp_q[$];
  bit         m_en[N];
  int         m_x[N];
  int         m_y[N];
  logic [2:0] m_c[N];

  display_scan #(.H_RES(H), .V_RES(V), .NUM_SPR(N), .COL_W(CW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .clear_req(clear_req),
    .spr_en   (spr_en),
    .spr_x    (spr_x),
    .spr_y    (spr_y),
    .spr_col  (spr_col),
    .grid     (grid),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_spr(input int i, input bit en, input int sx, input int sy, input logic [2:0] c);
    spr_en[i]         = en;
    spr_x[8*i +: 8]   = sx[7:0];
    spr_y[7*i +: 7]   = sy[6:0];
    spr_col[CW*i +: CW] = c;
    m_en[i] = en;
    m_x[i]  = sx;
    m_y[i]  = sy;
    m_c[i]  = c;
  endtask

  function automatic logic [2:0] model_col(input int px, input int py);
    for (int i = 0; i < N; i++)
      if (m_en[i] && m_x[i] == px && m_y[i] == py && m_x[i] < H && m_y[i] < V) return m_c[i];
    if (grid[py*H + px]) return C_GRN;
    return C_BLK;
  endfunction

  task automatic push_pass(input bit is_clear);
    pix_t e;
    for (int py = 0; py < V; py++)
      for (int px = 0; px < H; px++) begin
        e.px = px[7:0];
        e.py = py[6:0];
        e.pc = is_clear ? C_BLK : model_col(px, py);
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start(input bit clr);
    @(negedge clk);
    start = 1'b1;
    clear_req = clr;
    @(negedge clk);
    start = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wait_first_plot();
    int n;
    n = 0;
    while (plot !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("first_plot_timeout", {31'd0, plot}, 32'd1);
  endtask

  // mode 1: start re-pulse at mid-pass; mode 2: sprite0 x moves 3->9 at row 30
  task automatic consume_pass(input int mode, input string tag);
    pix_t e;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_plot"}, {31'd0, plot}, 32'd1);
      check({tag, "_pix"}, {14'd0, x, y, colour}, {14'd0, e});
      if (mode == 1 && i == NPIX / 2) start = 1'b1;
      if (mode == 1 && i == NPIX / 2 + 1) start = 1'b0;
      if (mode == 2 && i == 30 * H) spr_x[7:0] = 8'd9;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      i++;
    end
    check({tag, "_plot_low_at_done"}, {31'd0, plot}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {30'd0, busy, plot}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    clear_req = 1'b0;
    spr_en = '0;
    spr_x = '0;
    spr_y = '0;
    spr_col = '0;
    grid = '0;
    for (int i = 0; i < N; i++) set_spr(i, 1'b0, 0, 0, C_BLK);
    #15;
    check("rst_outputs", {14'd0, x, y, colour}, 32'd0);
    check("rst_flags", {29'd0, plot, busy, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Pass A: clear followed by an empty draw, contiguous
    push_pass(1'b1);
    push_pass(1'b0);
    pulse_start(1'b1);
    wait_first_plot();
    consume_pass(0, "clear_draw");

    // Pass B: sprite priority, sprite over grid, ignored restart
    grid[3*H + 7] = 1'b1;
    set_spr(0, 1'b1, 5, 0, C_RED);
    set_spr(1, 1'b1, 5, 0, C_BLU);
    set_spr(2, 1'b1, 7, 3, C_BLU);
    set_spr(3, 1'b0, 20, 20, C_RED);
    push_pass(1'b0);
    pulse_start(1'b0);
    wait_first_plot();
    consume_pass(1, "prio");

    // Reset mid-pass at pixel 1000
    pulse_start(1'b0);
    wait_first_plot();
    for (int i = 0; i < 1000; i++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_flags", {29'd0, plot, busy, done}, 32'd0);
    check("abort_outputs", {14'd0, x, y, colour}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort_quiet", {29'd0, plot, busy, done}, 32'd0);
    end

    // Pass C: starts at origin, disabled sprite exposes grid, mid-pass sprite move
    set_spr(0, 1'b1, 3, 60, C_RED);
    set_spr(1, 1'b1, 5, 0, C_BLU);
    set_spr(2, 1'b0, 7, 3, C_BLU);
    set_spr(3, 1'b1, 200, 5, C_RED);
`ifndef DISPLAY_SCAN_LATCH_EN
    m_x[0] = 9;
`endif
    push_pass(1'b0);
    pulse_start(1'b0);
    wait_first_plot();
    check("restart_origin", {24'd0, x}, 32'd0);
    consume_pass(2, "move");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
